// File: rtl/rme.sv
// rme -- SHA-256 message-expansion (message schedule) block.
//
// A one-cycle start_in pulse in IDLE captures the 16-word block i_m0..i_m15
// (i_m0 = M0, first/most significant word) in a LOAD cycle, then RUN streams
// the 64 schedule words W[0..63], one per clock, on o_message. o_round counts
// the words emitted (wrapping 63->0 on W[63]); o_FSM_state exposes the state
// encoding (IDLE=00, LOAD=01, RUN=10, DONE=11) to the compression datapath.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, ACTIVE-HIGH despite the name
//   start_in     start pulse, sampled only in IDLE
//   i_m0..i_m15  block words, sampled only in LOAD
//   o_message    registered schedule word W[t]
//   o_round      round counter (6 bits)
//   o_FSM_state  current state encoding (2 bits)
//
// Optional build macro RME_ASSERT_EN compiles in simulation-only protocol
// checks; the datapath is identical with or without it.
module rme #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] i_m0,
  input  logic [DATA_WIDTH-1:0] i_m1,
  input  logic [DATA_WIDTH-1:0] i_m2,
  input  logic [DATA_WIDTH-1:0] i_m3,
  input  logic [DATA_WIDTH-1:0] i_m4,
  input  logic [DATA_WIDTH-1:0] i_m5,
  input  logic [DATA_WIDTH-1:0] i_m6,
  input  logic [DATA_WIDTH-1:0] i_m7,
  input  logic [DATA_WIDTH-1:0] i_m8,
  input  logic [DATA_WIDTH-1:0] i_m9,
  input  logic [DATA_WIDTH-1:0] i_m10,
  input  logic [DATA_WIDTH-1:0] i_m11,
  input  logic [DATA_WIDTH-1:0] i_m12,
  input  logic [DATA_WIDTH-1:0] i_m13,
  input  logic [DATA_WIDTH-1:0] i_m14,
  input  logic [DATA_WIDTH-1:0] i_m15,
  output logic [DATA_WIDTH-1:0] o_message,
  output logic [5:0]            o_round,
  output logic [1:0]            o_FSM_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t                          state_q, state_d;
  logic [5:0]                      round_q, round_d;
  logic [DATA_WIDTH-1:0]           msg_q, msg_d;
  // 16-word sliding window; element 0 is the oldest word (next to emit).
  logic [15:0][DATA_WIDTH-1:0]     win_q, win_d;
  logic [DATA_WIDTH-1:0]           new_word;

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sig0(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sig1(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Window position j holds W[t+j]; this is W[t+16] from W[t+14], W[t+9],
  // W[t+1], W[t].
  assign new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    msg_d   = msg_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        round_d = '0;
        if (start_in) state_d = LOAD;
      end
      LOAD: begin
        win_d   = {i_m15, i_m14, i_m13, i_m12, i_m11, i_m10, i_m9, i_m8,
                   i_m7,  i_m6,  i_m5,  i_m4,  i_m3,  i_m2,  i_m1, i_m0};
        round_d = '0;
        state_d = RUN;
      end
      RUN: begin
        msg_d   = win_q[0];
        round_d = round_q + 6'd1;   // natural 6-bit wrap gives 63 -> 0
        win_d   = {new_word, win_q[15:1]};
        if (round_q == 6'd63) state_d = DONE;
      end
      DONE: begin
        round_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      msg_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      msg_q   <= msg_d;
      win_q   <= win_d;
    end
  end

  assign o_message   = msg_q;
  assign o_round     = round_q;
  assign o_FSM_state = state_q;

`ifdef RME_ASSERT_EN
  always @(posedge clk) begin
    if (!rst_n) begin
      if (state_q != RUN && state_q != DONE && round_d != round_q)
        $error("rme: o_round changing outside RUN/DONE (state %b)", state_q);
      if (start_in && state_q != IDLE)
        $warning("rme: start_in high outside IDLE is ignored (state %b)", state_q);
      if ((state_d != state_q) && (2'(state_d) != 2'(state_q + 2'd1)))
        $error("rme: illegal state transition %b -> %b", state_q, state_d);
    end
  end
`endif

endmodule

// File: tb/tb_rme.sv
// Self-checking bench for rme: directed block, random blocks with start
// noise, repeat of a block, and an asynchronous abort mid-RUN.
module tb_rme;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [31:0] m [16];
  logic [31:0] o_message;
  logic [5:0]  o_round;
  logic [1:0]  o_FSM_state;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [31:0] w [64];       // reference schedule
  logic [31:0] exp_msg;      // reference value of o_message

  rme #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in),
    .i_m0(m[0]),   .i_m1(m[1]),   .i_m2(m[2]),   .i_m3(m[3]),
    .i_m4(m[4]),   .i_m5(m[5]),   .i_m6(m[6]),   .i_m7(m[7]),
    .i_m8(m[8]),   .i_m9(m[9]),   .i_m10(m[10]), .i_m11(m[11]),
    .i_m12(m[12]), .i_m13(m[13]), .i_m14(m[14]), .i_m15(m[15]),
    .o_message(o_message), .o_round(o_round), .o_FSM_state(o_FSM_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Textbook SHA-256 schedule over a flat 64-entry array.
  task automatic build_sched();
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st,
                         input logic [5:0] rnd, input logic [31:0] msg);
    chk({tag, "_state"}, {30'd0, o_FSM_state}, {30'd0, st});
    chk({tag, "_round"}, {26'd0, o_round}, {26'd0, rnd});
    chk({tag, "_msg"}, o_message, msg);
  endtask

  // Runs one block from IDLE. abort_round > 0 asserts reset asynchronously
  // while o_round shows that value. noise toggles start_in and input words
  // during RUN. golden adds the known W[16] check for the directed block.
  task automatic run_block(input int abort_round, input bit noise, input bit golden);
    build_sched();
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    chk_all("load", 2'b01, 6'd0, exp_msg);
    @(negedge clk);
    chk_all("run0", 2'b10, 6'd0, exp_msg);
    for (int n = 1; n <= 64; n++) begin
      if (noise) begin
        start_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) m[i] = $urandom;
      end
      if (abort_round > 0 && n - 1 == abort_round) begin
        #2 rst_n = 1'b1;
        #1 exp_msg = '0;
        chk_all("abort", 2'b00, 6'd0, exp_msg);
        start_in = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk_all("post_abort", 2'b00, 6'd0, exp_msg);
        return;
      end
      @(negedge clk);
      exp_msg = w[n-1];
      chk_all("run", (n == 64) ? 2'b11 : 2'b10, 6'(n % 64), exp_msg);
      if (golden && n == 17) chk("w16_golden", o_message, 32'h84844442);
    end
    start_in = 1'b0;
    @(negedge clk);
    chk_all("idle", 2'b00, 6'd0, exp_msg);
  endtask

  initial begin
    rst_n    = 1'b1;
    start_in = 1'b0;
    exp_msg  = '0;
    for (int i = 0; i < 16; i++) m[i] = '0;

    // Reset held: everything cleared.
    #1 chk_all("reset", 2'b00, 6'd0, 32'd0);
    @(negedge clk); @(negedge clk);
    chk_all("reset_held", 2'b00, 6'd0, 32'd0);
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_all("idle_wait", 2'b00, 6'd0, 32'd0);
    end

    // Directed block 11111111..FFFFFFFF, 12345678.
    for (int i = 0; i < 15; i++) m[i] = 32'h11111111 * (i + 1);
    m[15] = 32'h12345678;
    run_block(0, 1'b0, 1'b1);

    // Same block again back-to-back: identical output expected.
    run_block(0, 1'b0, 1'b1);

    // Random blocks with start_in and input-word noise during RUN.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      run_block(0, 1'b1, 1'b0);
    end

    // Abort at round 30, then a fresh block from W[0].
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(30, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rme.md
# rme

Message-expansion block of the SHA-256 core. On a one-cycle `start_in` pulse it captures the 16-word (512-bit) block, then streams the 64-word message schedule W[0..63], one word per clock. The output feeds the compression round datapath. `o_round` and `o_FSM_state` sequence that datapath.

## Interface

- `DATA_WIDTH`, default 32, word width; the SHA-256 functions are defined only for 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-high reset. Asserted = 1 despite the name; it is not active-low.
- `start_in` input 1: start pulse, sampled only in IDLE.
- `i_m0` … `i_m15` input `DATA_WIDTH` each: block words M0..M15; `i_m0` is the first (most significant) word.
- `o_message` output `DATA_WIDTH`: registered schedule word W[t].
- `o_round` output 6: round counter.
- `o_FSM_state` output 2: current FSM state encoding.

## Operation

- Internal 16-word window, w[0] = oldest word.
- **IDLE (2'b00):**
  - `o_round` = 0; `o_message` holds.
  - `start_in`=1 at a rising edge → LOAD.
- **LOAD (2'b01), one cycle:**
  - window ← {i_m0..i_m15}, `o_round` ← 0.
  - → RUN.
- **RUN (2'b10), each cycle:**
  - `o_message` ← w[0]; `o_round` ← `o_round`+1.
  - Window shifts left by one word; the new w[15] = σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - On the edge that emits W[63], `o_round` wraps 63→0 and the state goes to DONE.
- **DONE (2'b11), one cycle:**
  - `o_message` holds W[63], `o_round` = 0.
  - → IDLE.
- `start_in` outside IDLE is ignored; no restart mid-block.
- Input words are sampled only in LOAD; they may change freely afterwards.

## Timing

- Reset values: `o_message`=0, `o_round`=0, `o_FSM_state`=2'b00; the window clears to 0.
- Reset asserted mid-block aborts immediately, with no clock needed; a new start is required after release.
- `start_in` high at edge k:
  - LOAD after k, RUN after k+1.
  - After edge k+1+n (n = 1..64): `o_message` = W[n-1]. `o_round` = n for n ≤ 63, and 0 for n = 64.
  - DONE after k+65; IDLE after k+66.
- Output word lags the round count by one: during RUN, `o_message` = W[`o_round`−1].
- W[0..15] equal the inputs verbatim; W[16..63] come from the recurrence.
- Busy from LOAD to DONE inclusive (66 cycles). The next start is accepted at the first edge in IDLE.

## Configuration

- `RME_ASSERT_EN`: when defined, compiles in simulation-only checks:
  - error if `o_round` changes outside RUN/DONE;
  - warning if `start_in` is high outside IDLE;
  - error if the state encoding leaves the legal sequence 00→01→10→11→00.
- Not defined: no checks are compiled; RTL behaviour is identical.

## Test plan

- Reset: hold `rst_n`=1 → all outputs 0, state 2'b00. Release with `start_in`=0 → stays IDLE indefinitely.
- Inputs 11111111, 22222222, … FFFFFFFF, 12345678; pulse start → `o_round`=1..16 show 11111111..12345678 in order, state 2'b10.
- Same block → the 17th word (round 17) = 84844442. All 64 words match a golden SHA-256 schedule model.
- Full sequence → state 00→01→10 (64 cycles)→11→00. W[63] is shown with `o_round`=0 in DONE; 66 busy cycles total.
- `start_in` pulsed during RUN → no effect on sequence or values. A second start in IDLE repeats identical output.
- `rst_n` asserted mid-RUN (round 30) → outputs 0 asynchronously. A fresh start restarts from W[0].
